// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clock_divider_pkg;

    // Per-channel operating state.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } ch_state_t;

    // Smallest usable divide ratio; anything below it is clamped up.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clock_divider_ch.sv
// One divided-clock channel: counter, active divisor, deferred reload
// and a glitch-free stop that always finishes the current high phase.
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    ch_state_t        state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_act_reg, div_act_next;
    logic             pending_reg, pending_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             busy_reg, busy_next;

    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W:0]   half_next;
    logic             wrap;

    // Clamp the requested ratio so a channel never runs faster than clk/2.
    always_comb begin
        div_clamped = div;
        if (div < DIV_W'(MIN_DIV)) begin
            div_clamped = DIV_W'(MIN_DIV);
        end
    end

    assign wrap = (cnt_reg == (div_act_reg - DIV_W'(1)));

    // Next-state logic; RUN and STOP_PEND count identically, and a stop is
    // only taken once the output is already low so no phase is shortened.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_act_next = div_act_reg;
        pending_next = pending_reg;
        tick_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                pending_next = 1'b0;
                if (enable) begin
                    state_next   = ST_RUN;
                    div_act_next = div_clamped;
                    tick_next    = 1'b1;
                end
            end
            ST_RUN, ST_STOP_PEND: begin
                if (load) begin
                    pending_next = 1'b1;
                end
                if (!enable && !clk_out_reg) begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    pending_next = 1'b0;
                end else begin
                    state_next = enable ? ST_RUN : ST_STOP_PEND;
                    if (wrap) begin
                        cnt_next  = '0;
                        tick_next = 1'b1;
                        if (pending_reg || load) begin
                            div_act_next = div_clamped;
                            pending_next = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                cnt_next     = '0;
                pending_next = 1'b0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the counter value they describe.
    always_comb begin
        half_next    = ({1'b0, div_act_next} + (DIV_W+1)'(1)) >> 1;
        busy_next    = (state_next != ST_IDLE);
        clk_out_next = busy_next && ({1'b0, cnt_next} < half_next);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            div_act_reg <= DIV_W'(MIN_DIV);
            pending_reg <= 1'b0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            div_act_reg <= div_act_next;
            pending_reg <= pending_next;
            clk_out_reg <= clk_out_next;
            tick_reg    <= tick_next;
            busy_reg    <= busy_next;
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign busy    = busy_reg;

endmodule

// File: rtl/clock_divider.sv
// Multi-channel clock divider: NUM_CH independent channels sharing LOAD.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic [NUM_CH-1:0]       ENABLE,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    input  logic                    LOAD,
    output logic [NUM_CH-1:0]       CLK_OUT,
    output logic [NUM_CH-1:0]       TICK,
    output logic [NUM_CH-1:0]       BUSY
);

    // One channel per divided clock, each with its own ratio slice.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clock_divider_ch #(
                .DIV_W (DIV_W)
            ) u_ch (
                .clk     (CLOCK),
                .rst_n   (RESET_N),
                .enable  (ENABLE[gi]),
                .div     (DIV[gi*DIV_W +: DIV_W]),
                .load    (LOAD),
                .clk_out (CLK_OUT[gi]),
                .tick    (TICK[gi]),
                .busy    (BUSY[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: stimulus pushes expected outputs per
// cycle, a monitor pops and compares one cycle after each rising edge.
module tb_clock_divider;

    logic        CLOCK;
    logic        RESET_N;
    logic [1:0]  ENABLE;
    logic [15:0] DIV;
    logic        LOAD;
    logic [1:0]  CLK_OUT;
    logic [1:0]  TICK;
    logic [1:0]  BUSY;

    typedef struct {
        int         cyc;
        logic [1:0] clk;
        logic [1:0] tick;
        logic [1:0] busy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cycle_cnt = 0;
    int   checks    = 0;
    int   failures  = 0;

    clock_divider #(
        .NUM_CH (2),
        .DIV_W  (8)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .ENABLE  (ENABLE),
        .DIV     (DIV),
        .LOAD    (LOAD),
        .CLK_OUT (CLK_OUT),
        .TICK    (TICK),
        .BUSY    (BUSY)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cycle_cnt <= cycle_cnt + 1;

    function automatic void chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cycle_cnt, act, exp);
        end
    endfunction

    // Monitor: compare every expectation due at the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
                e = sb.pop_front();
                chk({e.name, ".clk_out"}, CLK_OUT, e.clk);
                chk({e.name, ".tick"},    TICK,    e.tick);
                chk({e.name, ".busy"},    BUSY,    e.busy);
                $display("txn %s cycle=%0d clk_out=%b tick=%b busy=%b", e.name, e.cyc, CLK_OUT, TICK, BUSY);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string name, input logic [1:0] en, input logic [7:0] d0,
                        input logic [7:0] d1, input logic ld, input logic [1:0] ec,
                        input logic [1:0] et, input logic [1:0] eb);
        exp_t e;
        ENABLE = en;
        DIV    = {d1, d0};
        LOAD   = ld;
        e.cyc  = cycle_cnt + 1;
        e.clk  = ec;
        e.tick = et;
        e.busy = eb;
        e.name = name;
        sb.push_back(e);
        @(negedge CLOCK);
        LOAD = 1'b0;
    endtask

    // Several steps with constant inputs; patterns list the first cycle in the MSB.
    task automatic seq(input string name, input int n, input logic [1:0] en,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eb,
                       input logic [15:0] c0, input logic [15:0] t0,
                       input logic [15:0] c1, input logic [15:0] t1);
        for (int i = 0; i < n; i++) begin
            step(name, en, d0, d1, 1'b0, {c1[n-1-i], c0[n-1-i]}, {t1[n-1-i], t0[n-1-i]}, eb);
        end
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        ENABLE  = 2'b00;
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N = 1'b0;
        ENABLE  = 2'b00;
        DIV     = 16'h0;
        LOAD    = 1'b0;
        #2;
        chk("reset.clk_out", CLK_OUT, 2'b00);
        chk("reset.busy",    BUSY,    2'b00);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        // Idle after reset: nothing runs without ENABLE.
        step("idle", 2'b00, 8'd4, 8'd5, 1'b1, 2'b00, 2'b00, 2'b00);

        // ch0 divide-by-4 and ch1 divide-by-5 running together.
        seq("div4_div5", 10, 2'b11, 8'd4, 8'd5, 2'b11,
            16'b1100110011, 16'b1000100010, 16'b1110011100, 16'b1000010000);
        step("stop_ab1", 2'b00, 8'd4, 8'd5, 1'b0, 2'b00, 2'b00, 2'b01);
        step("stop_ab2", 2'b00, 8'd4, 8'd5, 1'b0, 2'b00, 2'b00, 2'b00);

        // ch1 with DIV=0 is clamped to 2.
        seq("clamp0", 6, 2'b10, 8'd0, 8'd0, 2'b10,
            16'b0, 16'b0, 16'b101010, 16'b101010);
        step("clamp_stop", 2'b00, 8'd0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);

        // DIV=8, enable dropped at cnt=1: high phase completes, then BUSY falls.
        seq("div8_run", 2, 2'b01, 8'd8, 8'd0, 2'b01, 16'b11, 16'b10, 16'b0, 16'b0);
        step("div8_sp2", 2'b00, 8'd8, 8'd0, 1'b0, 2'b01, 2'b00, 2'b01);
        step("div8_sp3", 2'b00, 8'd8, 8'd0, 1'b0, 2'b01, 2'b00, 2'b01);
        step("div8_low", 2'b00, 8'd8, 8'd0, 1'b0, 2'b00, 2'b00, 2'b01);
        step("div8_idle", 2'b00, 8'd8, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);
        step("div8_quiet", 2'b00, 8'd8, 8'd0, 1'b0, 2'b00, 2'b00, 2'b00);

        // DIV=4 running, LOAD with DIV=6 at cnt=1; then DIV change without LOAD.
        pulse_reset();
        seq("ld_start", 2, 2'b01, 8'd4, 8'd0, 2'b01, 16'b11, 16'b10, 16'b0, 16'b0);
        step("ld_pulse", 2'b01, 8'd6, 8'd0, 1'b1, 2'b00, 2'b00, 2'b01);
        seq("ld_div6", 8, 2'b01, 8'd6, 8'd0, 2'b01,
            16'b01110001, 16'b01000001, 16'b0, 16'b0);
        seq("noload_div3", 6, 2'b01, 8'd3, 8'd0, 2'b01,
            16'b110001, 16'b000001, 16'b0, 16'b0);

        // Enable glitch inside the high phase, then LOAD exactly at a wrap.
        pulse_reset();
        step("gl_on",  2'b01, 8'd4, 8'd0, 1'b0, 2'b01, 2'b01, 2'b01);
        step("gl_off", 2'b00, 8'd4, 8'd0, 1'b0, 2'b01, 2'b00, 2'b01);
        step("gl_back", 2'b01, 8'd4, 8'd0, 1'b0, 2'b00, 2'b00, 2'b01);
        seq("gl_cont", 3, 2'b01, 8'd4, 8'd0, 2'b01, 16'b011, 16'b010, 16'b0, 16'b0);
        seq("wrap_pre", 2, 2'b01, 8'd4, 8'd0, 2'b01, 16'b00, 16'b00, 16'b0, 16'b0);
        step("wrap_load", 2'b01, 8'd2, 8'd0, 1'b1, 2'b01, 2'b01, 2'b01);
        seq("wrap_div2", 2, 2'b01, 8'd2, 8'd0, 2'b01, 16'b01, 16'b01, 16'b0, 16'b0);

        // Reset mid-high-phase drops CLK_OUT at once; restart only via ENABLE.
        pulse_reset();
        step("rst_run", 2'b01, 8'd4, 8'd0, 1'b0, 2'b01, 2'b01, 2'b01);
        #2;
        RESET_N = 1'b0;
        ENABLE  = 2'b00;
        #1;
        chk("async_rst.clk_out", CLK_OUT, 2'b00);
        chk("async_rst.tick",    TICK,    2'b00);
        chk("async_rst.busy",    BUSY,    2'b00);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        seq("post_rst", 2, 2'b00, 8'd4, 8'd0, 2'b00, 16'b0, 16'b0, 16'b0, 16'b0);
        // LOAD together with IDLE->RUN leaves no pending reload behind.
        step("restart_ld", 2'b01, 8'd4, 8'd0, 1'b1, 2'b01, 2'b01, 2'b01);
        seq("restart_run", 5, 2'b01, 8'd2, 8'd0, 2'b01,
            16'b10011, 16'b00010, 16'b0, 16'b0);

        ENABLE = 2'b00;
        repeat (3) @(negedge CLOCK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divided-clock channels.
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel's divide-ratio field.
REQ-003 SHALL have port CLOCK  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ENABLE  input  NUM_CH  per-channel run request, level-sensitive.
REQ-006 SHALL have port DIV  input  NUM_CH*DIV_W  per-channel divide ratio N; channel i uses bits [i*DIV_W +: DIV_W].
REQ-007 SHALL have port LOAD  input  1  one-cycle pulse requesting that all running channels adopt DIV at their next period boundary.
REQ-008 SHALL have port CLK_OUT  output  NUM_CH  divided clock per channel, registered.
REQ-009 SHALL have port TICK  output  NUM_CH  one-cycle pulse coincident with each CLK_OUT rising edge, registered.
REQ-010 SHALL have port BUSY  output  NUM_CH  high whenever the channel is not IDLE, registered.

Function
REQ-011 Each channel SHALL hold an active divisor div_act, a counter cnt (0..div_act-1) and a state from {IDLE, RUN, STOP_PEND}.
REQ-012 Any DIV value below 2 SHALL be clamped to 2 when captured.
REQ-013 CLK_OUT SHALL be high when cnt < ceil(div_act/2) and low otherwise, giving exactly 50% duty for even N and one extra high cycle for odd N.
REQ-014 In RUN, cnt SHALL increment each cycle and wrap from div_act-1 to 0.
REQ-015 IDLE->RUN: when ENABLE[i]=1 is sampled, the channel SHALL capture DIV into div_act and set cnt=0, so that CLK_OUT=1 and TICK=1 in the next cycle (one-cycle latency).
REQ-016 RUN with ENABLE[i]=0 and CLK_OUT low SHALL go to IDLE on the next cycle.
REQ-017 RUN with ENABLE[i]=0 and CLK_OUT high SHALL go to STOP_PEND, completing the high phase unshortened.
REQ-018 STOP_PEND SHALL go to IDLE at the first cycle CLK_OUT would be low; if ENABLE[i] returns to 1 first, it SHALL go back to RUN with cnt unbroken.
REQ-019 In IDLE, CLK_OUT=0, TICK=0, BUSY=0 and cnt=0.
REQ-020 CLK_OUT SHALL never produce a high or low pulse shorter than its programmed phase, except under reset.
REQ-021 A LOAD pulse SHALL set a per-channel pending flag in each non-IDLE channel; LOAD in IDLE SHALL be ignored.
REQ-022 At a wrap (cnt==div_act-1) with pending set, the channel SHALL capture DIV into div_act and clear pending; the new period starts with cnt=0.
REQ-023 DIV changes without LOAD SHALL NOT affect a running channel.
REQ-024 LOAD coinciding with a wrap SHALL be applied at that same wrap.
REQ-025 LOAD coinciding with the IDLE->RUN transition SHALL have no additional effect, since DIV is captured anyway.
REQ-026 Channels SHALL be fully independent apart from the shared LOAD.

Reset
REQ-027 RESET_N low SHALL, asynchronously, force every channel to IDLE with cnt=0, div_act=2, pending=0, and CLK_OUT=0, TICK=0, BUSY=0.
REQ-028 Reset asserted mid-operation, including mid-high-phase, SHALL drop CLK_OUT immediately.
REQ-029 After RESET_N deasserts, a channel SHALL restart only via REQ-015.

Structure
REQ-030 Package clock_divider_pkg SHALL hold the channel state enum typedef and constant MIN_DIV=2.
REQ-031 Sub-module clock_divider_ch SHALL implement one channel; clock_divider SHALL generate NUM_CH instances and distribute LOAD to them.

Verification
REQ-032 Reset; DIV[0]=4; ENABLE[0]=1 at cycle 0 -> CLK_OUT[0]=1,1,0,0 repeating from cycle 1; TICK[0] high at cycles 1,5,9.
REQ-033 DIV[1]=5; ENABLE[1]=1 -> CLK_OUT[1] high 3 / low 2; DIV[1]=0 -> toggles every cycle (clamped to 2).
REQ-034 DIV=8 running; ENABLE drops at cnt=1 -> CLK_OUT stays high through cnt=3, then 0; BUSY falls one cycle later; no TICK follows.
REQ-035 DIV=4 running; LOAD with DIV=6 at cnt=1 -> current period ends after 4 cycles; next period is high 3 / low 3.
REQ-036 ENABLE drops and returns within the high phase -> no glitch; period unchanged.
REQ-037 RESET_N low mid-high-phase -> CLK_OUT=0 before the next CLOCK edge; all outputs stay 0 until ENABLE is re-sampled.
